sh_intc_arbiter: RTL
====================

// Module: sh_intc_arbiter
// PURPOSE
//  On-chip interrupt controller for the SH CPU core. Holds the INTC registers (IPRA/IPRB/VCRA-D/VCRWDT/ICR)
//  and arbitrates 12 on-chip sources plus NMI by level and fixed order.
//  Presents one registered IntReq_t to the CPU and retires it on the CPU's IntAck_t handshake.
// PARAMETERS
//  NMI_SYNC  2  number of flops synchronising NMI_N before edge detection (>=2)
// PORTS
//  CLK      in   1   system clock
//  RST_N    in   1   asynchronous reset, active low
//  CE       in   1   clock enable; all state advances only when CE=1
//  REG_A    in   8   register byte address within FFFFFExx page; bit0 ignored (16-bit regs)
//  REG_DI   in   16  write data
//  REG_DO   out  16  read data, masked by each register's RMASK; 0 for unmapped addresses
//  REG_BA   in   2   byte enables {hi,lo}
//  REG_WE   in   1   write strobe (one CE cycle)
//  REG_RD   in   1   read strobe; REG_DO valid same cycle (combinational from registers)
//  NMI_N    in   1   NMI pin
//  SRC_INT  in   12  level-sensitive source requests: 0 DIVU,1 DMA0,2 DMA1,3 WDT-ITI,4 BSC-CMI,
//                    5 SCI-ERI,6 RXI,7 TXI,8 TEI,9 FRT-ICI,10 OCI,11 OVI
//  DIVU_VEC in   7   VCRDIV vector; DMA_VEC in 16 {VCRDMA1.VC,VCRDMA0.VC}
//  INT_REQ  out  IntReq_t  request to CPU {LVL,VEC,RES,REQ}
//  INT_ACK  in   IntAck_t  CPU acknowledge {LVL,ACK}
//  SRC_ACK  out  13  one-hot pulse (1 CE cycle) naming the acknowledged source; bit12 = NMI
// BEHAVIOUR
//  - Reset: registers to their _INIT values (all 0); INT_REQ=INT_REQ_RESET; SRC_ACK=0; NMI pending=0.
//  - Writes apply WMASK per byte lane; ICR.NMIL read-only = synchronised NMI pin level.
//  - Levels: DIVU/DMA0/DMA1<-IPRA.DIVUIP/DMACIP; ITI/CMI<-IPRA.WDTIP; SCI*<-IPRB.SCIIP; FRT*<-IPRB.FRTIP.
//  - Vectors: ITI=WITV, CMI=BCMV, ERI/RXI=SERV/SRXV, TXI/TEI=STXV/STEV, ICI/OCI=FICV/FOCV, OVI=FOVV,
//    zero-extended to 8 bits; DIVU/DMA from inputs.
//  - A source with level 0 never requests. Winner = highest level; tie -> lowest index.
//  - NMI: edge per ICR.NMIE (0 falling,1 rising) latches pending; NMI beats all: LVL=15, VEC=11.
//  - FSM IDLE: any candidate -> REQ next CE cycle with REQ=1, LVL/VEC of winner (1-cycle latency).
//  - REQ: re-arbitrate every CE cycle (higher arrival replaces VEC/LVL); no candidate -> REQ=0, IDLE.
//  - REQ & INT_ACK.ACK: pulse SRC_ACK for current winner, REQ=0, go ACKW; NMI pending cleared.
//  - ACKW: wait INT_ACK.ACK=0, then IDLE (re-arbitration resumes next cycle).
//  - NMI edge in same cycle as NMI ack: stays pending (new edge wins).
//  - IPR/VCR write during REQ: new level/vector visible next CE cycle; REQ drops if level -> 0.
//  - RES always 0. CE=0: outputs hold, SRC_ACK held 0 width-wise not re-pulsed.
//  - Reset mid-handshake: FSM -> IDLE, REQ=0, pending NMI lost.
// CONFIGURATION
//  SH_INTC_IRL_EN defined: adds IRL_N in 4 (external level = ~IRL_N) and EXT_VEC in 8.
//    IRL ranks above all on-chip sources at equal level; VEC = ICR.VECMD ? EXT_VEC : 64+(level>>1);
//    SRC_ACK widens to 14 (bit13 = IRL).
//  Undefined: no IRL ports, ICR.VECMD stored/readable but has no effect.
// TESTING
//  - Reset, read FE60..FE68, FEE0..FEE4 -> all 0; write FFFF to FE68 -> read 7F00.
//  - IPRA=0x5000, VCRDIV=0x40, SRC_INT[0]=1 -> next CE: INT_REQ {5,0x40,0,1}; ACK -> SRC_ACK=0x001.
//  - IPRB=0x3700, SCI RXI & FRT OCI active -> FRT (lvl 7) wins; drop OCI in REQ -> RXI lvl 3 next cycle.
//  - Same level: DMA0 & DMA1 both active, DMA_VEC=0x5150 -> VEC=0x50; after ack, VEC=0x51.
//  - NMIE=0, NMI_N 1->0 during SCI request -> LVL=15 VEC=11; ack -> SRC_ACK bit12, NMI cleared.
//  - SH_INTC_IRL_EN: IRL_N=4'b1000 (lvl 7), VECMD=0 -> VEC=67; VECMD=1, EXT_VEC=0x90 -> VEC=0x90.

Source files
------------

// File: rtl/sh_intc_arbiter.sv
// SH on-chip interrupt controller: INTC register file, level/order arbitration of 12 sources plus NMI,
// and the registered request/acknowledge handshake. Optional external IRL input enabled by SH_INTC_IRL_EN.
module sh_intc_arbiter #(
  parameter int NMI_SYNC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce,
  input  logic [7:0]  reg_a,
  input  logic [15:0] reg_di,
  output logic [15:0] reg_do,
  input  logic [1:0]  reg_ba,
  input  logic        reg_we,
  input  logic        reg_rd,
  input  logic        nmi_n,
  input  logic [11:0] src_int,
  input  logic [6:0]  divu_vec,
  input  logic [15:0] dma_vec,
`ifdef SH_INTC_IRL_EN
  input  logic [3:0]  irl_n,
  input  logic [7:0]  ext_vec,
  output logic [13:0] src_ack,
`else
  output logic [12:0] src_ack,
`endif
  output logic [13:0] int_req,
  input  logic [4:0]  int_ack
);

`ifdef SH_INTC_IRL_EN
  localparam int ACK_W = 14;
`else
  localparam int ACK_W = 13;
`endif
  localparam logic [13:0] INT_REQ_RESET = '0;
  localparam logic [3:0]  NMI_IDX       = 4'd12;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACKW} state_t;

  state_t              state;
  logic [3:0]          cur_idx;
  logic [15:0]         ipra, iprb, vcra, vcrb, vcrc, vcrd, vcrwdt, icr;
  logic [NMI_SYNC-1:0] nmi_sync;
  logic                nmi_prev, nmi_pend, nmi_lvl, nmi_edge, nmi_retire;
  logic [7:0]          addr;
  logic [3:0]          src_lvl [12];
  logic [7:0]          src_vec [12];
  logic                win_any;
  logic [3:0]          win_lvl, win_idx;
  logic [7:0]          win_vec;
  logic                unused_ok;

  assign addr       = {reg_a[7:1], 1'b0};
  assign nmi_lvl    = nmi_sync[NMI_SYNC-1];
  assign nmi_edge   = icr[8] ? (nmi_lvl & ~nmi_prev) : (~nmi_lvl & nmi_prev);
  assign nmi_retire = (state == S_REQ) && int_ack[0] && (cur_idx == NMI_IDX);
  assign unused_ok  = &{1'b0, reg_a[0], int_ack[4:1]};

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] di,
                                        input logic [1:0] ba, input logic [15:0] mask);
    logic [15:0] v;
    v[15:8] = ba[1] ? di[15:8] : old[15:8];
    v[7:0]  = ba[0] ? di[7:0]  : old[7:0];
    return v & mask;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ipra <= '0; iprb <= '0; vcra <= '0; vcrb <= '0;
      vcrc <= '0; vcrd <= '0; vcrwdt <= '0; icr <= '0;
    end else if (ce && reg_we) begin
      case (addr)
        8'h60: iprb   <= merge(iprb,   reg_di, reg_ba, 16'hFF00);
        8'h62: vcra   <= merge(vcra,   reg_di, reg_ba, 16'h7F7F);
        8'h64: vcrb   <= merge(vcrb,   reg_di, reg_ba, 16'h7F7F);
        8'h66: vcrc   <= merge(vcrc,   reg_di, reg_ba, 16'h7F7F);
        8'h68: vcrd   <= merge(vcrd,   reg_di, reg_ba, 16'h7F00);
        8'hE0: icr    <= merge(icr,    reg_di, reg_ba, 16'h0101);
        8'hE2: ipra   <= merge(ipra,   reg_di, reg_ba, 16'hFFF0);
        8'hE4: vcrwdt <= merge(vcrwdt, reg_di, reg_ba, 16'h7F7F);
        default: ;
      endcase
    end
  end

  always_comb begin
    reg_do = '0;
    if (reg_rd) begin
      case (addr)
        8'h60: reg_do = iprb;
        8'h62: reg_do = vcra;
        8'h64: reg_do = vcrb;
        8'h66: reg_do = vcrc;
        8'h68: reg_do = vcrd;
        8'hE0: reg_do = {nmi_lvl, icr[14:0]};
        8'hE2: reg_do = ipra;
        8'hE4: reg_do = vcrwdt;
        default: reg_do = '0;
      endcase
    end
  end

  always_comb begin
    src_lvl[0]  = ipra[15:12]; src_vec[0]  = {1'b0, divu_vec};
    src_lvl[1]  = ipra[11:8];  src_vec[1]  = dma_vec[7:0];
    src_lvl[2]  = ipra[11:8];  src_vec[2]  = dma_vec[15:8];
    src_lvl[3]  = ipra[7:4];   src_vec[3]  = {1'b0, vcrwdt[14:8]};
    src_lvl[4]  = ipra[7:4];   src_vec[4]  = {1'b0, vcrwdt[6:0]};
    src_lvl[5]  = iprb[15:12]; src_vec[5]  = {1'b0, vcra[14:8]};
    src_lvl[6]  = iprb[15:12]; src_vec[6]  = {1'b0, vcra[6:0]};
    src_lvl[7]  = iprb[15:12]; src_vec[7]  = {1'b0, vcrb[14:8]};
    src_lvl[8]  = iprb[15:12]; src_vec[8]  = {1'b0, vcrb[6:0]};
    src_lvl[9]  = iprb[11:8];  src_vec[9]  = {1'b0, vcrc[14:8]};
    src_lvl[10] = iprb[11:8];  src_vec[10] = {1'b0, vcrc[6:0]};
    src_lvl[11] = iprb[11:8];  src_vec[11] = {1'b0, vcrd[14:8]};
  end

  // Strict '>' keeps the earliest candidate on a level tie, so IRL (checked first) and low indices win ties.
  always_comb begin
    win_any = 1'b0;
    win_lvl = '0;
    win_vec = '0;
    win_idx = '0;
`ifdef SH_INTC_IRL_EN
    if (~irl_n != 4'd0) begin
      win_any = 1'b1;
      win_lvl = ~irl_n;
      win_vec = icr[0] ? ext_vec : 8'd64 + {5'd0, win_lvl[3:1]};
      win_idx = 4'd13;
    end
`endif
    for (int i = 0; i < 12; i++) begin
      if (src_int[i] && (src_lvl[i] > win_lvl)) begin
        win_any = 1'b1;
        win_lvl = src_lvl[i];
        win_vec = src_vec[i];
        win_idx = 4'(i);
      end
    end
    if (nmi_pend) begin
      win_any = 1'b1;
      win_lvl = 4'd15;
      win_vec = 8'd11;
      win_idx = NMI_IDX;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      int_req  <= INT_REQ_RESET;
      cur_idx  <= '0;
      src_ack  <= '0;
      nmi_sync <= '0;
      nmi_prev <= 1'b0;
      nmi_pend <= 1'b0;
    end else begin
      src_ack <= '0;
      if (ce) begin
        nmi_sync <= {nmi_sync[NMI_SYNC-2:0], nmi_n};
        nmi_prev <= nmi_lvl;
        // A fresh edge landing on the NMI acknowledge cycle must survive the retire.
        if (nmi_edge)
          nmi_pend <= 1'b1;
        else if (nmi_retire)
          nmi_pend <= 1'b0;
        case (state)
          S_IDLE: begin
            if (win_any) begin
              int_req <= {win_lvl, win_vec, 1'b0, 1'b1};
              cur_idx <= win_idx;
              state   <= S_REQ;
            end
          end
          S_REQ: begin
            if (int_ack[0]) begin
              src_ack <= ACK_W'(1) << cur_idx;
              int_req <= INT_REQ_RESET;
              state   <= S_ACKW;
            end else if (win_any) begin
              int_req <= {win_lvl, win_vec, 1'b0, 1'b1};
              cur_idx <= win_idx;
            end else begin
              int_req <= INT_REQ_RESET;
              state   <= S_IDLE;
            end
          end
          S_ACKW: begin
            if (!int_ack[0])
              state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
